// File: rtl/loader_pkg.sv
// Shared state encoding, frame constants and LEN validation for the program loader.
// Defining LOADER_CHECKSUM_EN adds the trailing checksum byte and the S_CHK state.
package loader_pkg;

  localparam int              BYTE_W      = 8;
  localparam logic [BYTE_W-1:0] LEN_INVALID = 8'h00;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;
`endif

  // A frame must carry at least one byte and must fit the memory without wrapping.
  function automatic logic len_ok(input logic [BYTE_W-1:0] len, input int addr_w);
    return (len != LEN_INVALID) && (int'(len) <= (1 << addr_w));
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input handshake and memory write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/loader_csum.sv
// Running 8-bit sum of the data bytes of a frame, compared against the CHK byte.
module loader_csum
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_acc,
  input  logic [BYTE_W-1:0] i_data,
  input  logic [BYTE_W-1:0] i_chk,
  output logic              o_match
);

  logic [BYTE_W-1:0] r_sum;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_acc) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (r_sum == i_chk);

endmodule

// File: rtl/program_loader.sv
// Receives a LEN/data[/CHK] byte frame, writes it into CPU memory from address 0,
// then releases the CPU. Checksum byte and S_CHK exist only with LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            restart,
  program_loader_if.slave bus,
  output logic            cpu_hold,
  output logic            cpu_start,
  output logic            load_err,
  output logic [ADDR_W:0] load_count
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [BYTE_W-1:0] r_wdata;
  logic              r_start;
  logic              w_start;
  logic              w_ready;
  logic              w_accept;
  logic              w_len_ok;
  logic              w_last;

  assign w_ready  = (r_state == S_LEN) || (r_state == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                 || (r_state == S_CHK)
`endif
                 ;
  assign w_accept = bus.in_valid && w_ready;
  assign w_len_ok = len_ok(bus.in_data, ADDR_W);
  assign w_last   = ((r_count + CNT_W'(1)) == r_len);

`ifdef LOADER_CHECKSUM_EN
  logic w_match;

  loader_csum u_csum (
    .clock   (clock),
    .reset_n (reset_n),
    .i_clear (restart || (w_accept && (r_state == S_LEN))),
    .i_acc   (!restart && w_accept && (r_state == S_DATA)),
    .i_data  (bus.in_data),
    .i_chk   (bus.in_data),
    .o_match (w_match)
  );
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    if (restart) begin
      w_next = S_LEN;
    end else if (w_accept) begin
      case (r_state)
        S_LEN:   w_next = w_len_ok ? S_DATA : S_ERR;
        S_DATA: begin
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = S_CHK;
`else
            w_next  = S_RUN;
            w_start = 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_match) begin
            w_next  = S_RUN;
            w_start = 1'b1;
          end else begin
            w_next = S_ERR;
          end
        end
`endif
        default: w_next = r_state;
      endcase
    end
  end

  // A byte arriving together with restart is dropped, so it never reaches memory.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_len   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_start <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_start <= w_start;
      if (restart) begin
        r_count <= '0;
      end else if (w_accept && (r_state == S_LEN) && w_len_ok) begin
        r_len   <= CNT_W'(bus.in_data);
        r_count <= '0;
      end else if (w_accept && (r_state == S_DATA)) begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= bus.in_data;
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign cpu_hold      = (r_state != S_RUN);
  assign cpu_start     = r_start;
  assign load_err      = (r_state == S_ERR);
  assign load_count    = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed and random frames checked against a frame-level
// reference model; follows LOADER_CHECKSUM_EN to decide whether frames carry CHK.
module tb_program_loader;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  typedef logic [7:0] bytes_t [$];

  logic        clock = 1'b0;
  logic        reset_n;
  logic        restart;
  logic        cpu_hold;
  logic        cpu_start;
  logic        load_err;
  logic [AW:0] load_count;

  int tests = 0;
  int fails = 0;
  int wr_seen = 0;
  int start_seen = 0;

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(.ADDR_W(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .restart    (restart),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .cpu_start  (cpu_start),
    .load_err   (load_err),
    .load_count (load_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) wr_seen++;
    if (cpu_start === 1'b1) start_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one byte (after an optional random idle gap); acc reports whether it was taken.
  task automatic send_byte(input logic [7:0] b, input int max_gap, output logic acc);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      bus.in_data = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    acc = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  function automatic bytes_t mk_frame(input bytes_t data);
    bytes_t f;
    int     sum = 0;
    f.push_back(8'(data.size()));
    foreach (data[i]) begin
      f.push_back(data[i]);
      sum += int'(data[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    f.push_back(8'(sum));
`endif
    return f;
  endfunction

  // Frame-level reference: which byte decides the frame, how many data bytes, and the outcome.
  function automatic void model(input bytes_t f, output int last_idx, output int n_data,
                                output logic run);
    int len = int'(f[0]);
    int sum = 0;
    if (len == 0 || len > DEPTH) begin
      last_idx = 0;
      n_data   = 0;
      run      = 1'b0;
      return;
    end
    n_data = len;
    for (int i = 1; i <= len; i++) sum += int'(f[i]);
`ifdef LOADER_CHECKSUM_EN
    last_idx = len + 1;
    run      = (f[len+1] == 8'(sum));
`else
    last_idx = len;
    run      = 1'b1;
`endif
  endfunction

  task automatic run_frame(input string tag, input bytes_t f, input int max_gap);
    int   last_idx;
    int   n_data;
    logic run;
    logic acc;
    int   w0;
    int   s0;
    model(f, last_idx, n_data, run);
    w0 = wr_seen;
    s0 = start_seen;
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], max_gap, acc);
      check($sformatf("%s accept[%0d]", tag, i), 32'(acc), 32'(i <= last_idx));
      if (i >= 1 && i <= n_data) begin
        check($sformatf("%s mem_we[%0d]", tag, i), 32'(bus.mem_we), 32'd1);
        check($sformatf("%s mem_addr[%0d]", tag, i), 32'(bus.mem_addr), 32'(i - 1));
        check($sformatf("%s mem_wdata[%0d]", tag, i), 32'(bus.mem_wdata), 32'(f[i]));
      end else begin
        check($sformatf("%s no_we[%0d]", tag, i), 32'(bus.mem_we), 32'd0);
      end
      if (i == last_idx) begin
        check($sformatf("%s cpu_start", tag), 32'(cpu_start), 32'(run));
        check($sformatf("%s cpu_hold", tag), 32'(cpu_hold), 32'(!run));
        check($sformatf("%s load_err", tag), 32'(load_err), 32'(!run));
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd0);
        if (run) check($sformatf("%s load_count", tag), 32'(load_count), 32'(n_data));
      end
    end
    tick();
    check($sformatf("%s start_after", tag), 32'(cpu_start), 32'd0);
    check($sformatf("%s hold_after", tag), 32'(cpu_hold), 32'(!run));
    tick();
    check($sformatf("%s write_count", tag), 32'(wr_seen - w0), 32'(n_data));
    check($sformatf("%s start_count", tag), 32'(start_seen - s0), 32'(run));
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check($sformatf("%s rs load_err", tag), 32'(load_err), 32'd0);
    check($sformatf("%s rs cpu_hold", tag), 32'(cpu_hold), 32'd1);
    check($sformatf("%s rs in_ready", tag), 32'(bus.in_ready), 32'd1);
    check($sformatf("%s rs cpu_start", tag), 32'(cpu_start), 32'd0);
  endtask

  // One reset edge with a byte offered; optionally with restart high to show reset wins.
  task automatic do_reset(input string tag, input logic with_restart);
    reset_n      = 1'b0;
    restart      = with_restart;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
    check($sformatf("%s mem_we", tag), 32'(bus.mem_we), 32'd0);
    check($sformatf("%s mem_addr", tag), 32'(bus.mem_addr), 32'd0);
    check($sformatf("%s mem_wdata", tag), 32'(bus.mem_wdata), 32'd0);
    check($sformatf("%s cpu_hold", tag), 32'(cpu_hold), 32'd1);
    check($sformatf("%s cpu_start", tag), 32'(cpu_start), 32'd0);
    check($sformatf("%s load_err", tag), 32'(load_err), 32'd0);
    check($sformatf("%s load_count", tag), 32'(load_count), 32'd0);
    reset_n      = 1'b1;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bytes_t d;
    bytes_t f;
    logic   acc;

    reset_n      = 1'b0;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    do_reset("reset", 1'b0);

    d = '{8'h01, 8'h02, 8'h55};
    run_frame("basic", mk_frame(d), 0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'($urandom);
      bus.in_data  = 8'($urandom);
      tick();
      check("run idle mem_we", 32'(bus.mem_we), 32'd0);
      check("run idle cpu_hold", 32'(cpu_hold), 32'd0);
      check("run idle in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    do_restart("basic");

`ifdef LOADER_CHECKSUM_EN
    f = '{8'h03, 8'h01, 8'h02, 8'h55, 8'h59};
    run_frame("badchk", f, 0);
    do_restart("badchk");
`endif

    f = '{8'h00, 8'h12, 8'h34};
    run_frame("len0", f, 0);
    do_restart("len0");

    f = '{8'(DEPTH + 1), 8'h01};
    run_frame("len_over", f, 0);
    do_restart("len_over");

    d = {};
    for (int i = 0; i < DEPTH; i++) d.push_back(8'($urandom));
    run_frame("full_depth", mk_frame(d), 1);
    do_restart("full_depth");

    send_byte(8'h03, 0, acc);
    send_byte(8'h10, 0, acc);
    send_byte(8'h20, 0, acc);
    do_reset("midreset", 1'b1);
    d = '{8'hAA};
    run_frame("after_reset", mk_frame(d), 0);
    do_restart("after_reset");

    d = '{8'hDC, 8'hC1};
    run_frame("gaps", mk_frame(d), 3);
    do_restart("gaps");

    send_byte(8'h03, 0, acc);
    send_byte(8'h77, 0, acc);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h88;
    restart      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    restart      = 1'b0;
    check("abort mem_we", 32'(bus.mem_we), 32'd0);
    check("abort in_ready", 32'(bus.in_ready), 32'd1);
    check("abort cpu_hold", 32'(cpu_hold), 32'd1);
    check("abort load_err", 32'(load_err), 32'd0);
    tick();
    check("abort no_late_we", 32'(bus.mem_we), 32'd0);
    d = '{8'h11, 8'h22};
    run_frame("after_abort", mk_frame(d), 0);
    do_restart("after_abort");

    for (int n = 0; n < 8; n++) begin
      int r;
      int len;
      r   = int'($urandom_range(9, 0));
      len = (r == 9) ? DEPTH + 1 : (r == 8) ? DEPTH : r;
      d   = {};
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      f = mk_frame(d);
`ifdef LOADER_CHECKSUM_EN
      if ($urandom_range(3, 0) == 0) f[f.size()-1] = f[f.size()-1] ^ 8'h01;
`endif
      run_frame($sformatf("rand%0d", n), f, 2);
      do_restart($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
